// File: rtl/u409_flash_ctrl_if.sv
// rtl/u409_flash_ctrl_if.sv - CPU-side strobes and flash device pins for the U409 flash controller
interface u409_flash_ctrl_if;
  logic        TSn;
  logic        RnW;
  logic        FLASH_SPACE;
  logic        F_RDY;
  logic [23:1] A;
  logic        F_ENn;
  logic        F_READn;
  logic        F_WRITEn;
  logic        F_WPn;
  logic        F_RSTn;
  logic [1:0]  F_BANK;
  logic        F_ACK;

  modport master (
    output TSn, RnW, FLASH_SPACE, F_RDY, A,
    input  F_ENn, F_READn, F_WRITEn, F_WPn, F_RSTn, F_BANK, F_ACK
  );

  modport slave (
    input  TSn, RnW, FLASH_SPACE, F_RDY, A,
    output F_ENn, F_READn, F_WRITEn, F_WPn, F_RSTn, F_BANK, F_ACK
  );
endinterface

// File: rtl/u409_flash_ctrl.sv
// rtl/u409_flash_ctrl.sv - parallel boot flash controller: power-up reset, strobe sequencing, bank select, write-protect latch
module u409_flash_ctrl #(
  parameter int RST_CYCLES  = 16,
  parameter int READ_WAIT   = 4,
  parameter int WRITE_WAIT  = 3,
  parameter int RDY_TIMEOUT = 255
) (
  input  logic             CLK40,
  input  logic             RESET,
  u409_flash_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    INIT_RST, INIT_WAIT, IDLE, SETUP, RDY_WAIT,
    READ, WRITE, HOLD, ACK, CTRL_ACK
  } state_t;

  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] READ_LAST  = 16'(READ_WAIT - 1);
  localparam logic [15:0] WRITE_LAST = 16'(WRITE_WAIT - 1);
  localparam logic [15:0] RDY_LAST   = 16'(RDY_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        rdy_m, rdy_s;
  logic        rnw_l, rnw_nx;
  logic        wp, wp_nx;
  logic [1:0]  bank, bank_nx;
  logic        en_n, rd_n, wr_n, ack, rst_n;
  logic        start, ctrl;

  assign start = !bus.TSn && bus.FLASH_SPACE;
  assign ctrl  = start && !bus.RnW && (bus.A[23:8] == 16'hFFFF);

  always_ff @(posedge CLK40 or posedge RESET) begin
    if (RESET) begin
      state <= INIT_RST;
      cnt   <= '0;
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
      rnw_l <= 1'b0;
      wp    <= 1'b0;
      bank  <= 2'b00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rdy_m <= bus.F_RDY;
      rdy_s <= rdy_m;
      rnw_l <= rnw_nx;
      wp    <= wp_nx;
      bank  <= bank_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rnw_nx   = rnw_l;
    wp_nx    = wp;
    bank_nx  = bank;
    en_n     = 1'b1;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    ack      = 1'b0;
    rst_n    = 1'b1;
    case (state)
      INIT_RST: begin
        rst_n = 1'b0;
        if (cnt == RST_LAST) state_nx = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (rdy_s || cnt == RDY_LAST) state_nx = IDLE;
      end
      IDLE: begin
        if (ctrl) begin
          // Only the magic offset unlocks; any other control write re-locks.
          wp_nx    = (bus.A[7:1] == 7'h55);
          state_nx = CTRL_ACK;
        end else if (start) begin
          rnw_nx   = bus.RnW;
          bank_nx  = bus.A[23:22];
          state_nx = SETUP;
        end
      end
      SETUP: begin
        en_n     = 1'b0;
        state_nx = RDY_WAIT;
      end
      RDY_WAIT: begin
        en_n = 1'b0;
        // A ready timeout still completes the cycle rather than hanging the bus.
        if (rdy_s || cnt == RDY_LAST) begin
          if (rnw_l)    state_nx = READ;
          else if (!wp) state_nx = ACK;
          else          state_nx = WRITE;
        end
      end
      READ: begin
        en_n = 1'b0;
        rd_n = 1'b0;
        if (cnt == READ_LAST) state_nx = ACK;
      end
      WRITE: begin
        en_n = 1'b0;
        wr_n = 1'b0;
        if (cnt == WRITE_LAST) state_nx = HOLD;
      end
      HOLD: begin
        en_n     = 1'b0;
        state_nx = ACK;
      end
      ACK: begin
        en_n     = 1'b0;
        rd_n     = !rnw_l;
        ack      = 1'b1;
        state_nx = IDLE;
      end
      CTRL_ACK: begin
        ack      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = INIT_RST;
    endcase
    cnt_nx = (state_nx != state || state == IDLE) ? 16'd0 : cnt + 16'd1;
  end

  assign bus.F_ENn    = en_n;
  assign bus.F_READn  = rd_n;
  assign bus.F_WRITEn = wr_n;
  assign bus.F_WPn    = wp;
  assign bus.F_RSTn   = rst_n;
  assign bus.F_BANK   = bank;
  assign bus.F_ACK    = ack;

endmodule

// File: tb/tb_u409_flash_ctrl.sv
// tb/tb_u409_flash_ctrl.sv - scoreboard bench for the U409 flash controller
module tb_u409_flash_ctrl;

  typedef struct {
    int         cyc;
    int         en;
    int         rd;
    int         wr;
    logic [1:0] bank;
  } exp_t;

  typedef struct {
    logic        rnw;
    logic [23:0] a;
    int          lat;
    int          en;
    int          rd;
    int          wr;
    logic [1:0]  bank;
    logic        wp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0, rd_cnt = 0, wr_cnt = 0, viol = 0;
  exp_t sbq[$];
  vec_t vt[8];

  u409_flash_ctrl_if bus();

  u409_flash_ctrl dut (
    .CLK40(clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-transfer monitor: strobe widths accumulate between acks, compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      en_cnt = 0; rd_cnt = 0; wr_cnt = 0; viol = 0;
    end else begin
      if (!bus.F_ENn)    en_cnt++;
      if (!bus.F_READn)  rd_cnt++;
      if (!bus.F_WRITEn) wr_cnt++;
      if ((!bus.F_READn && !bus.F_WRITEn) || ((!bus.F_READn || !bus.F_WRITEn) && bus.F_ENn))
        viol++;
      if (bus.F_ACK) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("en_low_cycles", en_cnt, e.en);
          chk("read_low_cycles", rd_cnt, e.rd);
          chk("write_low_cycles", wr_cnt, e.wr);
          chk("bank", int'(bus.F_BANK), int'(e.bank));
          chk("strobe_order", viol, 0);
        end
        en_cnt = 0; rd_cnt = 0; wr_cnt = 0; viol = 0;
      end
    end
  end

  task automatic ts_pulse(input logic rnw, input logic [23:0] a, input logic space);
    bus.TSn = 1'b0;
    bus.FLASH_SPACE = space;
    bus.RnW = rnw;
    bus.A = a[23:1];
    @(negedge clk);
    bus.TSn = 1'b1;
    bus.FLASH_SPACE = 1'b0;
  endtask

  task automatic do_xfer(input logic rnw, input logic [23:0] a, input int lat,
                         input int en, input int rd, input int wr, input logic [1:0] bank);
    exp_t e;
    @(negedge clk);
    e.cyc = cyc + lat;
    e.en = en; e.rd = rd; e.wr = wr; e.bank = bank;
    sbq.push_back(e);
    ts_pulse(rnw, a, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", sbq.size(), 0);
    sbq.delete();
    repeat (2) @(negedge clk);
    chk("idle_strobes", int'({bus.F_ENn, bus.F_READn, bus.F_WRITEn}), 7);
  endtask

  // Called on a negedge; asserts reset, checks outputs, releases and times F_RSTn.
  task automatic do_reset();
    int n = 0;
    rst = 1'b1;
    #1;
    chk("reset_outputs",
        int'({bus.F_RSTn, bus.F_ENn, bus.F_READn, bus.F_WRITEn, bus.F_WPn, bus.F_BANK, bus.F_ACK}),
        8'h70);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (bus.F_RSTn == 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_low_cycles", n, 16);
    ts_pulse(1'b1, 24'h000000, 1'b1);
    repeat (8) @(negedge clk);
    chk("init_ts_ignored", en_cnt, 0);
  endtask

  initial begin
    int m, r, k;
    exp_t e;
    vt[0] = '{1'b1, 24'h400000, 7, 7, 5, 0, 2'b01, 1'b0};
    vt[1] = '{1'b0, 24'h800010, 3, 3, 0, 0, 2'b10, 1'b0};
    vt[2] = '{1'b0, 24'hFFFFAA, 1, 0, 0, 0, 2'b10, 1'b1};
    vt[3] = '{1'b0, 24'h800020, 7, 7, 0, 3, 2'b10, 1'b1};
    vt[4] = '{1'b1, 24'h000100, 7, 7, 5, 0, 2'b00, 1'b1};
    vt[5] = '{1'b1, 24'hFFFFAA, 7, 7, 5, 0, 2'b11, 1'b1};
    vt[6] = '{1'b0, 24'hFFFF10, 1, 0, 0, 0, 2'b11, 1'b0};
    vt[7] = '{1'b0, 24'h400000, 3, 3, 0, 0, 2'b01, 1'b0};

    bus.TSn = 1'b1;
    bus.RnW = 1'b1;
    bus.FLASH_SPACE = 1'b0;
    bus.F_RDY = 1'b1;
    bus.A = '0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      do_xfer(vt[i].rnw, vt[i].a, vt[i].lat, vt[i].en, vt[i].rd, vt[i].wr, vt[i].bank);
      wait_idle(50);
      chk("wp_latch", int'(bus.F_WPn), int'(vt[i].wp));
    end

    // TS outside flash space does nothing
    @(negedge clk);
    ts_pulse(1'b1, 24'h400000, 1'b0);
    repeat (10) @(negedge clk);
    chk("no_space_en", en_cnt, 0);

    // TS re-asserted mid-transfer yields one normal ack
    do_xfer(1'b1, 24'h000200, 7, 7, 5, 0, 2'b00);
    repeat (2) @(negedge clk);
    ts_pulse(1'b1, 24'hC00000, 1'b1);
    wait_idle(50);
    chk("bank_hold", int'(bus.F_BANK), 0);

    // F_RDY low for 100 cycles of RDY_WAIT, then ready
    bus.F_RDY = 1'b0;
    repeat (4) @(negedge clk);
    m = cyc;
    ts_pulse(1'b1, 24'h100000, 1'b1);
    repeat (99) @(negedge clk);
    r = cyc;
    bus.F_RDY = 1'b1;
    e.cyc = r + 7; e.en = r + 7 - m; e.rd = 5; e.wr = 0; e.bank = 2'b00;
    sbq.push_back(e);
    k = 0;
    while (bus.F_READn && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rdy_rise_to_strobe_2to3", int'(k >= 2 && k <= 3), 1);
    wait_idle(50);

    // F_RDY stuck low: timeout still completes exactly once
    bus.F_RDY = 1'b0;
    repeat (4) @(negedge clk);
    do_xfer(1'b1, 24'h400000, 261, 261, 5, 0, 2'b01);
    wait_idle(400);
    bus.F_RDY = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during READ aborts without an ack
    @(negedge clk);
    ts_pulse(1'b1, 24'h800000, 1'b1);
    repeat (3) @(negedge clk);
    chk("mid_read_strobe", int'(bus.F_READn), 0);
    do_reset();
    chk("wp_after_reset", int'(bus.F_WPn), 0);

    do_xfer(1'b1, 24'h400000, 7, 7, 5, 0, 2'b01);
    wait_idle(50);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/u409_flash_ctrl.md
Name: u409_flash_ctrl

Overview:
- Parallel boot/flash controller on U409, directly downstream of the address decoder.
- Consumes the decoder's FLASH_SPACE qualifier together with the 68040 bus strobes. Drives the flash device control pins.
- Returns a single-cycle F_ACK to the transfer-acknowledge stage, which turns it into TACKn.
- Also owns flash power-up reset, bank select and a software write-protect latch.

Parameters:
- RST_CYCLES, 16: CLK40 cycles F_RSTn is held low after reset release.
- READ_WAIT, 4: CLK40 cycles F_READn is low before data is acknowledged (1..15).
- WRITE_WAIT, 3: CLK40 cycles F_WRITEn is low (1..15).
- RDY_TIMEOUT, 255: maximum CLK40 cycles spent waiting for synchronised F_RDY (1..255).

Ports:
- CLK40  in  1  40MHz bus clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- TSn  in  1  68040 transfer start, active low.
- RnW  in  1  1 = read, 0 = write.
- FLASH_SPACE  in  1  combinational decode from the address decoder; high when the current address targets flash.
- F_RDY  in  1  flash ready/busy, asynchronous; 1 = ready.
- A  in  23  A[23:1], CPU address.
- F_ENn  out  1  flash chip enable, active low.
- F_READn  out  1  flash output enable, active low.
- F_WRITEn  out  1  flash write strobe, active low.
- F_WPn  out  1  write protect; 0 = protected.
- F_RSTn  out  1  flash reset, active low.
- F_BANK  out  2  bank select.
- F_ACK  out  1  one-cycle transfer complete pulse to the transfer-ack stage.

Behaviour:
Reset state (RESET high):
- State = INIT_RST, F_RSTn=0, F_ENn=1, F_READn=1, F_WRITEn=1, F_WPn=0, F_BANK=2'b00, F_ACK=0.
- Counters cleared; F_RDY synchroniser flops = 0.

F_RDY synchroniser:
- 2-flop synchroniser; RDY_S is the second flop.
- Logic only ever uses RDY_S.

Transfer start:
- START = !TSn && FLASH_SPACE, sampled on a CLK40 edge while in IDLE.
- TSn is ignored in every other state.

Control register access:
- CTRL = START && !RnW && A[23:8]==16'hFFFF.
- If A[7:1]==7'h55, set F_WPn=1; any other A[7:1] sets F_WPn=0.
- Next cycle goes to CTRL_ACK; no flash strobes are issued.

State machine:
- INIT_RST: count RST_CYCLES cycles, then F_RSTn=1 → INIT_WAIT.
- INIT_WAIT: go to IDLE when RDY_S=1 or after RDY_TIMEOUT cycles. START is ignored in INIT_* and is not latched.
- IDLE: on CTRL → CTRL_ACK. On START otherwise → SETUP, latching RnW and F_BANK←A[23:22] that edge.
- SETUP (1 cycle): F_ENn=0 → RDY_WAIT.
- RDY_WAIT: go to READ (latched RnW=1) or WRITE (latched RnW=0) when RDY_S=1 or the timeout counter reaches RDY_TIMEOUT. A timeout still completes the cycle; no bus error is raised.
- READ: F_READn=0 for READ_WAIT cycles → ACK. F_READn remains 0 during ACK.
- WRITE:
  - If F_WPn=0, no strobe is issued; go straight to ACK.
  - Otherwise F_WRITEn=0 for WRITE_WAIT cycles → HOLD.
- HOLD (1 cycle): F_WRITEn=1, F_ENn=0 → ACK.
- ACK (1 cycle): F_ACK=1 → IDLE. F_ENn and F_READn return to 1 on the IDLE edge.
- CTRL_ACK (1 cycle): F_ACK=1 → IDLE.

Strobe ordering:
- F_READn and F_WRITEn are never low simultaneously.
- Both are only ever low while F_ENn=0.

Bank and timing:
- F_BANK holds its value between transfers.
- Latency with ready flash, defaults (TS sampled at edge n):
  - Read: F_ACK at n+7 (SETUP n+1, RDY_WAIT n+2, READ n+3..n+6, ACK n+7).
  - Write: F_ACK at n+7 (WRITE n+3..n+5, HOLD n+6, ACK n+7).
- RESET mid-transfer forces all outputs to reset values immediately. No F_ACK is issued for the aborted transfer, and the INIT sequence reruns.
- F_WPn changes take effect from the next transfer.

Test Plan:
- Reset release, F_RDY=1 → F_RSTn low exactly 16 cycles then high; first transfer accepted no earlier than 2 cycles later (synchroniser).
- Read A=24'h400000 (bank 1), F_RDY=1 → F_BANK=01, F_ENn low n+1..n+7, F_READn low n+3..n+7, single F_ACK at n+7.
- Write before unlock → no F_WRITEn pulse, F_ACK at n+3. Then write A[23:1] with A[23:8]=FFFF, A[7:1]=55 → F_WPn=1, F_ACK next cycle. Repeat the flash write → F_WRITEn low 3 cycles, F_ACK at n+7.
- F_RDY held low 100 cycles during RDY_WAIT, then high → strobe starts 2–3 cycles after the rise. With F_RDY stuck low → timeout after 255 cycles, F_ACK still issued once.
- TSn asserted with FLASH_SPACE=0, and TSn re-asserted mid-transfer → no state change, no extra F_ACK.
- RESET pulsed during READ → F_READn/F_ENn high asynchronously, no F_ACK, F_RSTn low again 16 cycles.
